// File: rtl/fifo_wptr_full.sv
// fifo_wptr_full: write-domain pointer, Gray publish, read-pointer sync and full/level status for an async FIFO.
module fifo_wptr_full #(
    parameter int ADDRSIZE  = 4,
    parameter int AF_MARGIN = 2
) (
    input  logic                wclk,
    input  logic                wrst_n,
    input  logic                winc,
    input  logic [ADDRSIZE:0]   rptr,
    output logic [ADDRSIZE:0]   wptr,
    output logic [ADDRSIZE-1:0] waddr,
    output logic                wfull,
    output logic                walmost_full,
    output logic [ADDRSIZE:0]   wlevel,
    output logic                woverflow
);
    localparam int DEPTH = 1 << ADDRSIZE;
    localparam logic [ADDRSIZE:0] AF_TH = (ADDRSIZE+1)'(DEPTH - AF_MARGIN);

    logic [ADDRSIZE:0] wq1_rptr_q, wq2_rptr_q, wbin_q, wbin_d, wptr_q, wptr_d, wlevel_q, wlevel_d, rbin_s;
    logic              wfull_q, wfull_d, walmost_full_q, walmost_full_d, woverflow_q, woverflow_d;

    // Status is computed from the next pointer so an accepted write shows up after one edge.
    always_comb begin
        for (int i = 0; i <= ADDRSIZE; i++) rbin_s[i] = ^(wq2_rptr_q >> i);
        wbin_d         = wbin_q + {{ADDRSIZE{1'b0}}, winc & ~wfull_q};
        wptr_d         = (wbin_d >> 1) ^ wbin_d;
        wlevel_d       = wbin_d - rbin_s;
        wfull_d        = wptr_d == {~wq2_rptr_q[ADDRSIZE:ADDRSIZE-1], wq2_rptr_q[ADDRSIZE-2:0]};
        walmost_full_d = wlevel_d >= AF_TH;
        woverflow_d    = woverflow_q | (winc & wfull_q);
    end

    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            wq1_rptr_q     <= '0;
            wq2_rptr_q     <= '0;
            wbin_q         <= '0;
            wptr_q         <= '0;
            wlevel_q       <= '0;
            wfull_q        <= 1'b0;
            walmost_full_q <= 1'b0;
            woverflow_q    <= 1'b0;
        end else begin
            wq1_rptr_q     <= rptr;
            wq2_rptr_q     <= wq1_rptr_q;
            wbin_q         <= wbin_d;
            wptr_q         <= wptr_d;
            wlevel_q       <= wlevel_d;
            wfull_q        <= wfull_d;
            walmost_full_q <= walmost_full_d;
            woverflow_q    <= woverflow_d;
        end
    end

    assign wptr         = wptr_q;
    assign waddr        = wbin_q[ADDRSIZE-1:0];
    assign wfull        = wfull_q;
    assign walmost_full = walmost_full_q;
    assign wlevel       = wlevel_q;
    assign woverflow    = woverflow_q;
endmodule
